// File: rtl/rx_bit_timer_frac_pkg.sv
// ---------------------------------------------------------------------------
// usb_rx_timer_pkg
//   Shared constants and helpers for the USB RX bit-timing slice.
//   USB_FS_* : full-speed ratio of system clocks per line bit
//              (8 + 1/3 clocks per bit at the default system clock).
//   clog2_min1 : $clog2 that never returns 0, so a counter is at least 1 bit.
// ---------------------------------------------------------------------------
package usb_rx_timer_pkg;

  localparam int USB_FS_CLK_INT  = 8;
  localparam int USB_FS_FRAC_NUM = 1;
  localparam int USB_FS_FRAC_DEN = 3;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rx_bit_timer_frac_if.sv
// ---------------------------------------------------------------------------
// rx_bit_timer_frac_if
//   Control and strobe bundle between the edge detector / destuffer (master)
//   and the bit timer (slave).
//   enable_timer  master->slave  run the timer; low clears everything
//   resync        master->slave  one-cycle pulse on a detected line edge
//   invalid_bit   master->slave  current bit is stuffed (valid in strobe cycle)
//   sample_strobe slave->master  mid-bit sample point, stuffed bits included
//   shift_enable  slave->master  sample point of a valid bit
//   byte_complete slave->master  one-cycle pulse after the last bit of a word
//   bit_idx       slave->master  valid bits taken in the current word
// ---------------------------------------------------------------------------
interface rx_bit_timer_frac_if #(
  parameter int IDX_W = 3
);

  logic             enable_timer;
  logic             resync;
  logic             invalid_bit;
  logic             sample_strobe;
  logic             shift_enable;
  logic             byte_complete;
  logic [IDX_W-1:0] bit_idx;

  modport master (
    output enable_timer,
    output resync,
    output invalid_bit,
    input  sample_strobe,
    input  shift_enable,
    input  byte_complete,
    input  bit_idx
  );

  modport slave (
    input  enable_timer,
    input  resync,
    input  invalid_bit,
    output sample_strobe,
    output shift_enable,
    output byte_complete,
    output bit_idx
  );

endinterface

// File: rtl/rx_bit_timer_frac_frac_period_gen.sv
// ---------------------------------------------------------------------------
// frac_period_gen
//   Bresenham accumulator that spreads FRAC_NUM/FRAC_DEN extra clocks over
//   the bit stream. Each bit is CLK_INT clocks long, plus one when len_carry
//   is set.
//   clk, rst   system clock, asynchronous active-high reset
//   advance    one-cycle pulse at the last clock of the current bit
//   clear      synchronous clear of remainder and carry (timer disabled)
//   len_carry  1 = the bit now running is CLK_INT+1 clocks long
// ---------------------------------------------------------------------------
module frac_period_gen
  import usb_rx_timer_pkg::*;
#(
  parameter int FRAC_NUM = USB_FS_FRAC_NUM,
  parameter int FRAC_DEN = USB_FS_FRAC_DEN
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic clear,
  output logic len_carry
);

  localparam int ACC_W = clog2_min1(FRAC_DEN + 1);

  // One spare bit: acc + FRAC_NUM stays below 2*FRAC_DEN.
  localparam logic [ACC_W:0] NUM_E = (ACC_W + 1)'(FRAC_NUM);
  localparam logic [ACC_W:0] DEN_E = (ACC_W + 1)'(FRAC_DEN);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   acc_nxt;
  logic             carry_nxt;

  // The carry registered at a wrap describes the bit that starts next, so it
  // looks one fraction ahead: the new bit is long if its own share of the
  // fraction overflows the updated remainder. With 1/3 this yields 8,8,9
  // repeating, and the first bit after a clear is always short.
  always_comb begin
    sum       = {1'b0, acc} + NUM_E;
    acc_nxt   = (sum >= DEN_E) ? (sum - DEN_E) : sum;
    carry_nxt = ((acc_nxt + NUM_E) >= DEN_E);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      len_carry <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      len_carry <= 1'b0;
    end else if (advance) begin
      acc       <= acc_nxt[ACC_W-1:0];
      len_carry <= carry_nxt;
    end
  end

endmodule

// File: rtl/rx_bit_timer_frac.sv
// ---------------------------------------------------------------------------
// rx_bit_timer_frac
//   Bit-timing generator for the USB RX path. Runs a phase counter over a
//   fractional bit period (CLK_INT + FRAC_NUM/FRAC_DEN clocks), fires a
//   sample strobe at SAMPLE_PH, realigns to RESYNC_PH on a line edge, skips
//   stuffed bits, and pulses byte_complete after BITS_PER_WORD valid bits.
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   rx_bit_timer_frac_if.slave (enable/resync/invalid in,
//         sample_strobe/shift_enable/byte_complete/bit_idx out)
// ---------------------------------------------------------------------------
module rx_bit_timer_frac
  import usb_rx_timer_pkg::*;
#(
  parameter int CLK_INT       = USB_FS_CLK_INT,
  parameter int FRAC_NUM      = USB_FS_FRAC_NUM,
  parameter int FRAC_DEN      = USB_FS_FRAC_DEN,
  parameter int SAMPLE_PH     = 4,
  parameter int RESYNC_PH     = 1,
  parameter int BITS_PER_WORD = 8
) (
  input logic               clk,
  input logic               rst,
  rx_bit_timer_frac_if.slave bus
);

  // Phase reaches at most CLK_INT (last clock of a long bit).
  localparam int PH_W  = clog2_min1(CLK_INT + 1);
  localparam int IDX_W = clog2_min1(BITS_PER_WORD);

  localparam logic [PH_W-1:0]  LAST_SHORT  = PH_W'(CLK_INT - 1);
  localparam logic [PH_W-1:0]  SAMPLE_PH_V = PH_W'(SAMPLE_PH);
  localparam logic [PH_W-1:0]  RESYNC_PH_V = PH_W'(RESYNC_PH);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BITS_PER_WORD - 1);

  if (CLK_INT < 4) begin : g_err_clk_int
    $error("rx_bit_timer_frac: CLK_INT must be >= 4");
  end
  if (FRAC_DEN < 1) begin : g_err_frac_den
    $error("rx_bit_timer_frac: FRAC_DEN must be >= 1");
  end
  if (FRAC_NUM < 0 || FRAC_NUM >= FRAC_DEN) begin : g_err_frac_num
    $error("rx_bit_timer_frac: FRAC_NUM must be in [0, FRAC_DEN)");
  end
  if (SAMPLE_PH < 0 || SAMPLE_PH >= CLK_INT) begin : g_err_sample_ph
    $error("rx_bit_timer_frac: SAMPLE_PH must be in [0, CLK_INT)");
  end
  if (RESYNC_PH < 0 || RESYNC_PH >= CLK_INT) begin : g_err_resync_ph
    $error("rx_bit_timer_frac: RESYNC_PH must be in [0, CLK_INT)");
  end
  if (BITS_PER_WORD < 2) begin : g_err_bpw
    $error("rx_bit_timer_frac: BITS_PER_WORD must be >= 2");
  end

  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_last;
  logic             len_carry;
  logic             wrap;
  logic             strobe;
  logic             shift_en;
  logic [IDX_W-1:0] bit_idx_q;
  logic             byte_complete_q;

  assign phase_last = LAST_SHORT + PH_W'(len_carry);
  assign wrap       = bus.enable_timer & (phase == phase_last);

  // Strobe decodes the registered phase, so it still fires in a cycle that
  // also carries resync; it is held low during reset regardless of SAMPLE_PH.
  assign strobe   = bus.enable_timer & ~rst & (phase == SAMPLE_PH_V);
  assign shift_en = strobe & ~bus.invalid_bit;

  frac_period_gen #(
    .FRAC_NUM (FRAC_NUM),
    .FRAC_DEN (FRAC_DEN)
  ) u_frac_period_gen (
    .clk       (clk),
    .rst       (rst),
    .advance   (wrap),
    .clear     (~bus.enable_timer),
    .len_carry (len_carry)
  );

  // Resync overrides the increment and the wrap-to-zero, but the wrap still
  // advances the accumulator above so the fractional sequence is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (!bus.enable_timer) begin
      phase <= '0;
    end else if (bus.resync) begin
      phase <= RESYNC_PH_V;
    end else if (wrap) begin
      phase <= '0;
    end else begin
      phase <= phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx_q       <= '0;
      byte_complete_q <= 1'b0;
    end else if (!bus.enable_timer) begin
      bit_idx_q       <= '0;
      byte_complete_q <= 1'b0;
    end else begin
      byte_complete_q <= 1'b0;
      if (shift_en) begin
        if (bit_idx_q == IDX_LAST) begin
          bit_idx_q       <= '0;
          byte_complete_q <= 1'b1;
        end else begin
          bit_idx_q <= bit_idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Disable forces every output low in the same cycle, ahead of the
  // synchronous clear of the registers behind them.
  assign bus.sample_strobe = strobe;
  assign bus.shift_enable  = shift_en;
  assign bus.byte_complete = byte_complete_q & bus.enable_timer;
  assign bus.bit_idx       = bus.enable_timer ? bit_idx_q : '0;

endmodule

// File: tb/tb_rx_bit_timer_frac.sv
module tb_rx_bit_timer_frac;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic resync;
  logic invalid;

  always #5 clk = ~clk;

  rx_bit_timer_frac_if #(.IDX_W(3)) bus_a ();
  rx_bit_timer_frac_if #(.IDX_W(3)) bus_b ();

  assign bus_a.enable_timer = en;
  assign bus_a.resync       = resync;
  assign bus_a.invalid_bit  = invalid;
  assign bus_b.enable_timer = en;
  assign bus_b.resync       = resync;
  assign bus_b.invalid_bit  = invalid;

  rx_bit_timer_frac #(
    .CLK_INT(8), .FRAC_NUM(1), .FRAC_DEN(3),
    .SAMPLE_PH(4), .RESYNC_PH(1), .BITS_PER_WORD(8)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  rx_bit_timer_frac #(
    .CLK_INT(8), .FRAC_NUM(0), .FRAC_DEN(3),
    .SAMPLE_PH(4), .RESYNC_PH(1), .BITS_PER_WORD(8)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int strobe_q[$];
  int shift_q[$];
  int bc_q[$];
  int strobe_b_q[$];
  int bc_b_q[$];
  int exp_q[$];
  int idx_log[200];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag, input int obs[$], input int exp[$]);
    chk({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < obs.size()) ? obs[i] : -1, exp[i]);
  endtask

  task automatic clear_logs();
    strobe_q.delete();
    shift_q.delete();
    bc_q.delete();
    strobe_b_q.delete();
    bc_b_q.delete();
    for (int i = 0; i < 200; i++) idx_log[i] = -1;
  endtask

  // Sample all outputs mid-cycle for the current cycle index.
  task automatic sample();
    @(negedge clk);
    if (bus_a.sample_strobe) strobe_q.push_back(cyc);
    if (bus_a.shift_enable)  shift_q.push_back(cyc);
    if (bus_a.byte_complete) bc_q.push_back(cyc);
    if (bus_b.sample_strobe) strobe_b_q.push_back(cyc);
    if (bus_b.byte_complete) bc_b_q.push_back(cyc);
    if (cyc < 200) idx_log[cyc] = int'(bus_a.bit_idx);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle 0 is the cycle in which enable_timer first reads high.
  task automatic begin_run();
    @(posedge clk);
    #1;
    clear_logs();
    en  = 1'b1;
    cyc = 0;
  endtask

  task automatic end_run();
    en      = 1'b0;
    resync  = 1'b0;
    invalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    resync  = 1'b0;
    invalid = 1'b0;
    cyc     = 0;
    clear_logs();

    // Reset state, even with enable high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobe", int'(bus_a.sample_strobe), 0);
    chk("rst_shift",  int'(bus_a.shift_enable), 0);
    chk("rst_bc",     int'(bus_a.byte_complete), 0);
    chk("rst_idx",    int'(bus_a.bit_idx), 0);
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Test 1 (+ test 2 on the integer-period instance): free run.
    begin_run();
    for (int k = 0; k < 64; k++) begin
      sample();
      next_cycle();
    end
    exp_q = '{4, 12, 20, 29, 37, 45, 54, 62};
    chk_list("t1_strobe", strobe_q, exp_q);
    chk_list("t1_shift", shift_q, exp_q);
    exp_q = '{63};
    chk_list("t1_bc", bc_q, exp_q);
    chk("t1_idx0",  idx_log[0], 0);
    chk("t1_idx5",  idx_log[5], 1);
    chk("t1_idx13", idx_log[13], 2);
    chk("t1_idx21", idx_log[21], 3);
    chk("t1_idx30", idx_log[30], 4);
    chk("t1_idx38", idx_log[38], 5);
    chk("t1_idx46", idx_log[46], 6);
    chk("t1_idx55", idx_log[55], 7);
    chk("t1_idx63", idx_log[63], 0);
    exp_q = '{4, 12, 20, 28, 36, 44, 52, 60};
    chk_list("t2_strobe", strobe_b_q, exp_q);
    exp_q = '{61};
    chk_list("t2_bc", bc_b_q, exp_q);
    end_run();

    // Test 3: stuffed bit at the 3rd strobe; invalid off-strobe is ignored.
    begin_run();
    for (int k = 0; k < 72; k++) begin
      invalid = (k == 20 || k == 25);
      sample();
      next_cycle();
    end
    exp_q = '{4, 12, 20, 29, 37, 45, 54, 62, 70};
    chk_list("t3_strobe", strobe_q, exp_q);
    exp_q = '{4, 12, 29, 37, 45, 54, 62, 70};
    chk_list("t3_shift", shift_q, exp_q);
    exp_q = '{71};
    chk_list("t3_bc", bc_q, exp_q);
    chk("t3_idx21", idx_log[21], 2);
    chk("t3_idx28", idx_log[28], 2);
    chk("t3_idx71", idx_log[71], 0);
    end_run();

    // Test 4a: resync at phase 6; fractional sequence continues unchanged.
    begin_run();
    for (int k = 0; k < 40; k++) begin
      resync = (k == 6);
      sample();
      next_cycle();
    end
    exp_q = '{4, 10, 18, 26, 35};
    chk_list("t4a_strobe", strobe_q, exp_q);
    chk("t4a_idx11", idx_log[11], 2);
    end_run();

    // Test 4b: resync coinciding with the sample phase.
    begin_run();
    for (int k = 0; k < 20; k++) begin
      resync = (k == 4);
      sample();
      next_cycle();
    end
    exp_q = '{4, 8, 16};
    chk_list("t4b_strobe", strobe_q, exp_q);
    end_run();

    // Test 5: drop enable after 5 valid bits, re-raise at cycle 42.
    begin_run();
    for (int k = 0; k < 90; k++) begin
      en = !(k >= 38 && k < 42);
      sample();
      next_cycle();
    end
    exp_q = '{4, 12, 20, 29, 37, 46, 54, 62, 71, 79, 87};
    chk_list("t5_strobe", strobe_q, exp_q);
    exp_q.delete();
    chk_list("t5_bc", bc_q, exp_q);
    chk("t5_idx37", idx_log[37], 4);
    chk("t5_idx38", idx_log[38], 0);
    chk("t5_idx42", idx_log[42], 0);
    chk("t5_idx47", idx_log[47], 1);
    end_run();

    // Test 6: async reset mid-word, between clock edges.
    begin_run();
    for (int k = 0; k < 30; k++) begin
      sample();
      if (k < 29) next_cycle();
    end
    chk("t6_pre_strobe", int'(bus_a.sample_strobe), 1);
    chk("t6_pre_idx", int'(bus_a.bit_idx), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_strobe", int'(bus_a.sample_strobe), 0);
    chk("t6_async_idx", int'(bus_a.bit_idx), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    cyc = 0;
    for (int k = 0; k < 35; k++) begin
      sample();
      next_cycle();
    end
    exp_q = '{4, 12, 20, 29};
    chk_list("t6_strobe", strobe_q, exp_q);
    chk("t6_idx30", idx_log[30], 4);
    end_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
